// File: rtl/dcache_ctrl_nway.sv
// dcache_ctrl_nway: N-way set-associative, write-back, write-allocate
// data-cache controller. The way arrays are external. The controller keeps a
// tree pseudo-LRU per set, picks invalid ways first, and latches the victim
// when a miss is detected.
// Optional build macro DCACHE_PERF_CNT_EN adds hit/miss/write-back counters.
module dcache_ctrl_nway #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned TAG_W  = 9,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned OFF_W  = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_W-1:0]       mem_address,
  output logic                    mem_resp,
  output logic                    pmem_read,
  output logic                    pmem_write,
  input  logic                    pmem_resp,
  output logic [ADDR_W-1:0]       pmem_address,
  input  logic [WAYS-1:0]         way_hit,
  input  logic [WAYS-1:0]         way_valid,
  input  logic [WAYS-1:0]         way_dirty,
  input  logic [WAYS*TAG_W-1:0]   way_tag,
  output logic [WAYS-1:0]         load_way,
  output logic                    write_type,
  output logic                    cache_in_mux_sel,
  output logic [$clog2(WAYS)-1:0] wb_way_sel
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             wb_count
`endif
);

  localparam int unsigned WIDX = $clog2(WAYS);
  localparam int unsigned SETS = 1 << IDX_W;

  typedef enum logic [1:0] {HIT, WB, FETCH, FILL} state_t;

  state_t          state_q;
  logic [WIDX-1:0] victim_q;
  logic            miss_pend_q;
  logic [WAYS-2:0] plru_q [SETS];

  logic             req;
  logic             hit;
  logic [WIDX-1:0]  hit_idx;
  logic             inv_found;
  logic [WIDX-1:0]  inv_idx;
  logic [WIDX-1:0]  plru_vic;
  logic [WIDX-1:0]  victim_c;
  logic [WAYS-2:0]  plru_upd;
  logic [IDX_W-1:0] idx;
  logic             unused_off;

  assign req        = mem_read | mem_write;
  assign idx        = mem_address[OFF_W+IDX_W-1:OFF_W];
  assign unused_off = ^mem_address[OFF_W-1:0];
  assign victim_c   = inv_found ? inv_idx : plru_vic;

  // Lowest-index hit way and lowest-index invalid way
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_hit[w] && !hit) begin
        hit     = 1'b1;
        hit_idx = WIDX'(w);
      end
      if (!way_valid[w] && !inv_found) begin
        inv_found = 1'b1;
        inv_idx   = WIDX'(w);
      end
    end
  end

  // Walk the PLRU tree of the indexed set: victim path and updated bits for the hit way
  always_comb begin
    int unsigned vnode;
    int unsigned unode;
    logic        vb;
    logic        ub;
    plru_vic = '0;
    plru_upd = plru_q[idx];
    vnode    = 0;
    unode    = 0;
    vb       = 1'b0;
    ub       = 1'b0;
    for (int unsigned l = 0; l < WIDX; l++) begin
      vb                   = plru_q[idx][vnode];
      plru_vic[WIDX-1-l]   = vb;
      vnode                = 2 * vnode + 1 + 32'(vb);
      ub                   = hit_idx[WIDX-1-l];
      plru_upd[unode]      = ~ub;
      unode                = 2 * unode + 1 + 32'(ub);
    end
  end

  // Controller state, latched victim and per-set PLRU storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HIT;
      victim_q    <= '0;
      miss_pend_q <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      case (state_q)
        HIT: begin
          if (req) begin
            if (hit) begin
              plru_q[idx] <= plru_upd;
              miss_pend_q <= 1'b0;
            end else begin
              victim_q <= victim_c;
              state_q  <= way_dirty[victim_c] ? WB : FETCH;
            end
          end
        end
        WB:      if (pmem_resp) state_q <= FETCH;
        FETCH:   if (pmem_resp) state_q <= FILL;
        FILL: begin
          state_q     <= HIT;
          miss_pend_q <= 1'b1;
        end
        default: state_q <= HIT;
      endcase
    end
  end

  // Output decode; handshake outputs are gated so reset drops them without a clock
  always_comb begin
    mem_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    load_way         = '0;
    write_type       = 1'b0;
    cache_in_mux_sel = mem_write;
    wb_way_sel       = victim_q;
    pmem_address     = {mem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    case (state_q)
      HIT: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          if (mem_write) begin
            load_way         = WAYS'(1) << hit_idx;
            write_type       = 1'b1;
            cache_in_mux_sel = 1'b1;
          end
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim_q*TAG_W +: TAG_W], idx, {OFF_W{1'b0}}};
      end
      FETCH: pmem_read = 1'b1;
      FILL: begin
        load_way   = WAYS'(1) << victim_q;
        write_type = mem_write;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      load_way   = '0;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // Performance counters; the hit that completes a miss is not a hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state_q == HIT && req && hit && !miss_pend_q) hit_count <= hit_count + 32'd1;
      if (state_q == HIT && req && !hit) miss_count <= miss_count + 32'd1;
      if (state_q == WB && pmem_resp) wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dcache_ctrl_nway.md
Name: dcache_ctrl_nway

Overview:
Parametrised N-way set-associative, write-back, write-allocate data-cache controller, successor to the fixed 2-way controller. Sits between the CPU memory port and the physical-memory port and drives the way arrays, which stay external. Adds an internal per-set tree pseudo-LRU, invalid-way-first victim choice, and a victim latched at miss time.

Parameters:
WAYS, 4, associativity; power of two, at least 2
TAG_W, 9, tag width
IDX_W, 3, set-index width (index = mem_address[OFF_W+IDX_W-1:OFF_W])
OFF_W, 4, line-offset width (16-byte line)
ADDR_W, 16, address width; must equal TAG_W+IDX_W+OFF_W

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_address  in  ADDR_W  CPU address
mem_resp  out  1  CPU access complete
pmem_read  out  1  line-fetch request
pmem_write  out  1  line write-back request
pmem_resp  in  1  physical-memory done
pmem_address  out  ADDR_W  line-aligned physical address
way_hit  in  WAYS  per-way tag match AND valid
way_valid  in  WAYS  per-way valid bit of the indexed set
way_dirty  in  WAYS  per-way dirty bit of the indexed set
way_tag  in  WAYS*TAG_W  per-way stored tag; way w at [w*TAG_W +: TAG_W]
load_way  out  WAYS  one-hot array write enable
write_type  out  1  1 = CPU word merge and set dirty; 0 = clean line fill
cache_in_mux_sel  out  1  array data source: 1 = CPU data, 0 = pmem line
wb_way_sel  out  $clog2(WAYS)  way routed to pmem write data

Behaviour:
- States: HIT, WB, FETCH, FILL. Reset state is HIT. The CPU holds the request until mem_resp.
- Request = mem_read OR mem_write. When both are high, write takes priority. hit = OR of way_hit. If several way_hit bits are set, the lowest index wins.
- HIT state, request and hit:
  - mem_resp=1 combinationally in the same cycle.
  - On a write: load_way=onehot(hit way), write_type=1, cache_in_mux_sel=1.
  - PLRU of the indexed set is updated at the next posedge.
- HIT state, request and miss:
  - Victim = lowest-index invalid way; if all ways are valid, victim = PLRU victim.
  - The victim is latched into victim_q at the posedge.
  - Next state = WB if the victim is dirty, else FETCH.
- WB: pmem_write=1; wb_way_sel=victim_q; pmem_address={way_tag[victim_q], index, OFF_W zeros}. Stays in WB until pmem_resp, then goes to FETCH.
- FETCH: pmem_read=1; pmem_address=mem_address with the low OFF_W bits cleared. Stays until pmem_resp, then goes to FILL.
- FILL (one cycle):
  - load_way=onehot(victim_q), cache_in_mux_sel=mem_write, write_type=mem_write.
  - Next state is HIT, where the access now hits and responds.
  - The PLRU is updated only on the hit.
- Outside HIT and FILL, load_way=0; mem_resp=0 except in HIT.
- Tree PLRU storage: WAYS-1 bits per set, 2^IDX_W sets, in internal flops.
  - Node bit 0 means the victim is in the lower half; 1 means the upper half.
  - Node numbering is heap order: root = bit 0; children of node n are 2n+1 and 2n+2.
  - On access to way w, each node on w's path is set to point away from w.
- Reset (rst_n low, any state, including mid-WB or mid-FETCH):
  - State returns to HIT immediately.
  - pmem_read, pmem_write, mem_resp and load_way deassert without waiting for a clock.
  - All PLRU bits, victim_q and counters clear to 0.
- Default outputs: pmem_address = mem_address with offset cleared; wb_way_sel=victim_q; write_type=0; cache_in_mux_sel=mem_write.

Optional Feature:
DCACHE_PERF_CNT_EN
- Defined: adds outputs hit_count, miss_count, wb_count (each 32-bit).
  - hit_count increments on each HIT-state cycle with mem_resp=1 that is not the completion of a miss.
  - miss_count increments on each HIT to WB or HIT to FETCH transition.
  - wb_count increments on each WB to FETCH transition.
  - All wrap at 2^32 and clear on rst_n.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-FETCH: assert rst_n=0 while pmem_read=1 -> pmem_read=0 before the next clk edge; after release, state is HIT and the PLRU of every set is 000.
- Read hit, WAYS=4, mem_address=0x1234 (index 3), way_hit=0100 -> mem_resp=1 in the same cycle, load_way=0000; set 3 PLRU becomes bit0=0, bit2=1.
- Clean read miss, index 3, way_valid=1111, way_dirty=0000, PLRU 000 -> victim way0; FETCH with pmem_address=0x1230 held for 5 cycles until pmem_resp; FILL with load_way=0001, write_type=0; then hit and mem_resp.
- Dirty write miss, index 3, PLRU selects way1, way_dirty=0010, way_tag[1]=0x0A5 -> WB with pmem_address=0x52B0, wb_way_sel=1; then FETCH at 0x1230; FILL with load_way=0010, write_type=1, cache_in_mux_sel=1.
- Invalid-first, way_valid=1011 with any PLRU state -> victim way2, direct to FETCH, no WB.
- DCACHE_PERF_CNT_EN defined: 3 hits, 1 clean miss, 1 dirty miss -> hit_count=3, miss_count=2, wb_count=1.
